// File: rtl/zorro2_bus_master.sv
// zorro2_bus_master
// 68000-style asynchronous bus initiator. It turns single word/byte requests
// from internal engines (RAM clear/test, DMA) into an AS_n/UDS_n/LDS_n/RW_n
// bus cycle. It waits for DTACK_n or BERR_n, then returns read data and status.
//
// Ports
//   CLKCPU, RESET      : clock; synchronous active-high reset
//   REQ, REQ_RW_n, REQ_ADDR[23:1], REQ_UDS, REQ_LDS, REQ_WDATA
//                      : request port, sampled only while READY=1
//   READY, ACK, ERR, RDATA : request status / read data (valid with ACK)
//   A, D_OUT, D_OE, AS_n, UDS_n, LDS_n, RW_n : bus outputs
//   DTACK_n, BERR_n, D_IN                    : bus inputs
//
// Optional build macro BUS_TIMEOUT_EN:
//   - When it is defined, a WAIT that sees neither DTACK_n nor BERR_n for
//     TIMEOUT_CYCLES cycles ends with ERR=1.
//   - When it is undefined, WAIT holds until the responder answers.
module zorro2_bus_master #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        CLKCPU,
  input  logic        RESET,
  input  logic        REQ,
  input  logic        REQ_RW_n,
  input  logic [22:0] REQ_ADDR,
  input  logic        REQ_UDS,
  input  logic        REQ_LDS,
  input  logic [15:0] REQ_WDATA,
  output logic        READY,
  output logic        ACK,
  output logic        ERR,
  output logic [15:0] RDATA,
  output logic [22:0] A,
  output logic [15:0] D_OUT,
  output logic        D_OE,
  output logic        AS_n,
  output logic        UDS_n,
  output logic        LDS_n,
  output logic        RW_n,
  input  logic        DTACK_n,
  input  logic        BERR_n,
  input  logic [15:0] D_IN
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ASSERT, S_DSTRB, S_WAIT, S_LATCH, S_END
  } state_t;

  state_t      state, state_nx;
  logic        rw_q, uds_q, lds_q, cyc_q, err_q, err_set, timeout;
  logic [22:0] addr_q;
  logic [15:0] wdata_q, rdata_q;
  logic        accept, busy, ds_on;

  assign accept = (state == S_IDLE) && REQ;

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  // Counts completed WAIT cycles; restarts from 0 on every entry to WAIT.
  always_ff @(posedge CLKCPU) begin
    if (RESET || state != S_WAIT)
      wait_cnt <= '0;
    else if (wait_cnt != CNT_W'(TIMEOUT_CYCLES))
      wait_cnt <= wait_cnt + 1'b1;
  end

  assign timeout = (state == S_WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge CLKCPU) begin
    if (RESET) begin
      state   <= S_IDLE;
      rw_q    <= 1'b1;
      uds_q   <= 1'b0;
      lds_q   <= 1'b0;
      cyc_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        rw_q  <= REQ_RW_n;
        uds_q <= REQ_UDS;
        lds_q <= REQ_LDS;
        // A request with no byte lane enabled never reaches the bus.
        cyc_q <= REQ_UDS | REQ_LDS;
        err_q <= ~(REQ_UDS | REQ_LDS);
      end else if (err_set) begin
        err_q <= 1'b1;
      end
      // Both lanes are captured regardless of enables; the caller masks.
      if (state == S_LATCH && rw_q)
        rdata_q <= D_IN;
    end
  end

  // Address and write data are pure payload; they are qualified by state.
  always_ff @(posedge CLKCPU) begin
    if (accept) begin
      addr_q  <= REQ_ADDR;
      wdata_q <= REQ_WDATA;
    end
  end

  always_comb begin
    state_nx = state;
    err_set  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (REQ)
          state_nx = (REQ_UDS | REQ_LDS) ? S_ADDR : S_END;
      end
      S_ADDR:   state_nx = S_ASSERT;
      S_ASSERT: state_nx = rw_q ? S_WAIT : S_DSTRB;
      S_DSTRB:  state_nx = S_WAIT;
      S_WAIT: begin
        // BERR wins over a simultaneous DTACK.
        if (!BERR_n) begin
          state_nx = S_END;
          err_set  = 1'b1;
        end else if (!DTACK_n) begin
          state_nx = S_LATCH;
        end else if (timeout) begin
          state_nx = S_END;
          err_set  = 1'b1;
        end
      end
      S_LATCH:  state_nx = S_END;
      S_END:    state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Reads raise the data strobes together with AS_n.
  // Writes raise them one cycle later, after the data has settled.
  assign busy  = (state != S_IDLE);
  assign ds_on = ((state == S_ASSERT) && rw_q) || (state == S_DSTRB) ||
                 (state == S_WAIT) || (state == S_LATCH);

  always_comb begin
    READY = ~busy;
    ACK   = (state == S_END);
    ERR   = (state == S_END) && err_q;
    RDATA = rdata_q;
    A     = (busy && cyc_q) ? addr_q : '0;
    RW_n  = (busy && cyc_q) ? rw_q : 1'b1;
    D_OE  = busy && cyc_q && !rw_q;
    D_OUT = (busy && cyc_q && !rw_q) ? wdata_q : '0;
    AS_n  = !((state == S_ASSERT) || (state == S_DSTRB) ||
              (state == S_WAIT) || (state == S_LATCH));
    UDS_n = !(ds_on && uds_q);
    LDS_n = !(ds_on && lds_q);
  end

endmodule
